// File: rtl/udc_multicycle.sv
// udc_multicycle: multi-cycle main control unit for the MIPS-subset datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and stalls on the
// shared memory ready handshake. It flags unknown opcodes and counts retired
// instructions. Control outputs decode combinationally from state and the
// latched opcode.
// Optional feature macro: UDC_JUMP_EN (adds the J instruction through a JUMP state).
module udc_multicycle #(
  parameter int unsigned OPW   = 6,
  parameter int unsigned ALUCW = 3,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opCode,
  input  logic             mem_ready,
  output logic             PCwrite,
  output logic             IRwrite,
  output logic             IorD,
  output logic             BR_en,
  output logic [ALUCW-1:0] AluC,
  output logic             EnW,
  output logic             EnR,
  output logic             MUX1,
  output logic             branch,
  output logic             regDest,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [1:0]       PCsrc,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNTW-1:0]  retired
);

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);

  localparam logic [ALUCW-1:0] ALU_R   = ALUCW'(0);
  localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(1);
  localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(2);
  localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(3);
  localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(4);
  localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(5);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_TRAP, S_JUMP
  } state_t;

  state_t         state, state_n;
  logic [OPW-1:0] op_q;

  // State register and latched opcode; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      op_q  <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) op_q <= opCode;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNTW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retired <= '0;
    else if (instr_done) retired <= retired + CNTW'(1);
  end

  // Next-state and control decode.
  always_comb begin
    state_n    = state;
    PCwrite    = 1'b0;
    IRwrite    = 1'b0;
    IorD       = 1'b0;
    BR_en      = 1'b0;
    AluC       = '0;
    EnW        = 1'b0;
    EnR        = 1'b0;
    MUX1       = 1'b0;
    branch     = 1'b0;
    regDest    = 1'b0;
    ALUsrcA    = 1'b0;
    ALUsrcB    = 2'b00;
    PCsrc      = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;

    case (state)
      S_RST: state_n = S_FETCH;

      S_FETCH: begin
        EnR     = 1'b1;
        ALUsrcB = 2'b01;
        AluC    = ALU_ADD;
        PCwrite = mem_ready;
        IRwrite = mem_ready;
        if (mem_ready) state_n = S_DECODE;
      end

      S_DECODE: begin
        ALUsrcB = 2'b11;
        AluC    = ALU_ADD;
        case (opCode)
          OP_R, OP_ADDI, OP_ORI, OP_ANDI,
          OP_LW, OP_SW, OP_SLTI: state_n = S_EXEC;
          OP_BEQ:                state_n = S_BRANCH;
`ifdef UDC_JUMP_EN
          OP_J:                  state_n = S_JUMP;
`endif
          default:               state_n = S_TRAP;
        endcase
      end

      S_EXEC: begin
        ALUsrcA = 1'b1;
        ALUsrcB = (op_q == OP_R) ? 2'b00 : 2'b10;
        case (op_q)
          OP_R:    AluC = ALU_R;
          OP_ORI:  AluC = ALU_OR;
          OP_ANDI: AluC = ALU_AND;
          OP_SLTI: AluC = ALU_SLT;
          default: AluC = ALU_ADD;
        endcase
        state_n = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
      end

      S_MEM: begin
        IorD = 1'b1;
        EnR  = (op_q == OP_LW);
        EnW  = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            instr_done = 1'b1;
            state_n    = S_FETCH;
          end else begin
            state_n    = S_WB;
          end
        end
      end

      S_WB: begin
        BR_en      = 1'b1;
        regDest    = (op_q == OP_R);
        MUX1       = (op_q == OP_LW);
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end

      S_BRANCH: begin
        ALUsrcA    = 1'b1;
        ALUsrcB    = 2'b00;
        AluC       = ALU_SUB;
        branch     = 1'b1;
        PCsrc      = 2'b01;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end

      S_TRAP: begin
        illegal = 1'b1;
        state_n = S_FETCH;
      end

`ifdef UDC_JUMP_EN
      S_JUMP: begin
        PCwrite    = 1'b1;
        PCsrc      = 2'b10;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
`endif

      default: state_n = S_RST;
    endcase
  end

  // The latched opcode is only wide enough to matter in its low OPW bits; no further use.
endmodule

// File: tb/tb_udc_multicycle.sv
// Bench for udc_multicycle: table of instruction latencies/retire deltas,
// randomized instruction stream against a phase-level reference model,
// hand sequences for reset-in-MEM and small-counter wrap.
module tb_udc_multicycle;

  localparam int PH_RST = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3,
                 PH_MEM = 4, PH_WB = 5, PH_BRANCH = 6, PH_TRAP = 7, PH_JUMP = 8;

  localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100,
    ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101,
    LW = 6'b100011, SW = 6'b101011, BAD = 6'b111111;

  logic clk, rst_n, mem_ready;
  logic [5:0] opCode;

  logic PCwrite, IRwrite, IorD, BR_en, EnW, EnR, MUX1, branch, regDest, ALUsrcA, illegal, instr_done;
  logic [2:0] AluC;
  logic [1:0] ALUsrcB, PCsrc;
  logic [15:0] retired;

  logic PCwrite_b, IRwrite_b, IorD_b, BR_en_b, EnW_b, EnR_b, MUX1_b, branch_b, regDest_b, ALUsrcA_b, illegal_b, instr_done_b;
  logic [2:0] AluC_b;
  logic [1:0] ALUsrcB_b, PCsrc_b;
  logic [1:0] retired_b;

  logic [18:0] outs, outs_b;
  assign outs = {PCwrite, IRwrite, IorD, BR_en, AluC, EnW, EnR, MUX1, branch,
                 regDest, ALUsrcA, ALUsrcB, PCsrc, illegal, instr_done};
  assign outs_b = {PCwrite_b, IRwrite_b, IorD_b, BR_en_b, AluC_b, EnW_b, EnR_b, MUX1_b, branch_b,
                   regDest_b, ALUsrcA_b, ALUsrcB_b, PCsrc_b, illegal_b, instr_done_b};

  udc_multicycle dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .mem_ready(mem_ready),
    .PCwrite(PCwrite), .IRwrite(IRwrite), .IorD(IorD), .BR_en(BR_en), .AluC(AluC),
    .EnW(EnW), .EnR(EnR), .MUX1(MUX1), .branch(branch), .regDest(regDest),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .PCsrc(PCsrc), .illegal(illegal),
    .instr_done(instr_done), .retired(retired));

  udc_multicycle #(.CNTW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .mem_ready(mem_ready),
    .PCwrite(PCwrite_b), .IRwrite(IRwrite_b), .IorD(IorD_b), .BR_en(BR_en_b), .AluC(AluC_b),
    .EnW(EnW_b), .EnR(EnR_b), .MUX1(MUX1_b), .branch(branch_b), .regDest(regDest_b),
    .ALUsrcA(ALUsrcA_b), .ALUsrcB(ALUsrcB_b), .PCsrc(PCsrc_b), .illegal(illegal_b),
    .instr_done(instr_done_b), .retired(retired_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned model_cnt = 0;
  logic jump_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit goes_exec(input logic [5:0] op);
    return op inside {R, ADDI, ORI, ANDI, LW, SW, SLTI};
  endfunction

  // Expected control word for one cycle, straight from the per-phase rules.
  function automatic logic [18:0] model_out(input int ph, input logic [5:0] op, input logic mr);
    logic pcw, irw, iord, bren, enw, enr, mux1, br, rdst, srca, ill, done;
    logic [2:0] aluc;
    logic [1:0] srcb, pcsrc;
    {pcw, irw, iord, bren, enw, enr, mux1, br, rdst, srca, ill, done} = '0;
    aluc = 3'd0; srcb = 2'd0; pcsrc = 2'd0;
    case (ph)
      PH_FETCH:  begin enr = 1; srcb = 2'b01; aluc = 3'd1; pcw = mr; irw = mr; end
      PH_DECODE: begin srcb = 2'b11; aluc = 3'd1; end
      PH_EXEC: begin
        srca = 1;
        srcb = (op == R) ? 2'b00 : 2'b10;
        aluc = (op == R) ? 3'd0 : (op == ORI) ? 3'd2 : (op == ANDI) ? 3'd3 : (op == SLTI) ? 3'd4 : 3'd1;
      end
      PH_MEM:    begin iord = 1; enr = (op == LW); enw = (op == SW); done = (op == SW) && mr; end
      PH_WB:     begin bren = 1; rdst = (op == R); mux1 = (op == LW); done = 1; end
      PH_BRANCH: begin srca = 1; aluc = 3'd5; br = 1; pcsrc = 2'b01; done = 1; end
      PH_TRAP:   ill = 1;
      PH_JUMP:   begin pcw = 1; pcsrc = 2'b10; done = 1; end
      default:   ;
    endcase
    return {pcw, irw, iord, bren, aluc, enw, enr, mux1, br, rdst, srca, srcb, pcsrc, ill, done};
  endfunction

  // One cycle in RST right after reset release.
  task automatic rst_cycle();
    @(negedge clk);
    opCode = 6'($urandom); mem_ready = 1'($urandom);
    #1;
    check("rst_outs", 32'(outs), 32'(model_out(PH_RST, 6'd0, mem_ready)));
    check("rst_retired", 32'(retired), 32'(16'(model_cnt)));
    @(posedge clk);
  endtask

  // Run one instruction from FETCH, checking every cycle; returns DUT latency and retire delta.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                           output int lat, output int dret);
    int ph_q[$];
    logic mr_q[$];
    logic [15:0] r0;
    logic [18:0] e;
    for (int i = 0; i < fs; i++) begin ph_q.push_back(PH_FETCH); mr_q.push_back(1'b0); end
    ph_q.push_back(PH_FETCH);  mr_q.push_back(1'b1);
    ph_q.push_back(PH_DECODE); mr_q.push_back(1'($urandom));
    if (goes_exec(op)) begin
      ph_q.push_back(PH_EXEC); mr_q.push_back(1'($urandom));
      if (op == LW || op == SW) begin
        for (int i = 0; i < ms; i++) begin ph_q.push_back(PH_MEM); mr_q.push_back(1'b0); end
        ph_q.push_back(PH_MEM); mr_q.push_back(1'b1);
      end
      if (op != SW) begin ph_q.push_back(PH_WB); mr_q.push_back(1'($urandom)); end
    end else if (op == BEQ) begin
      ph_q.push_back(PH_BRANCH); mr_q.push_back(1'($urandom));
    end else if (op == J && jump_en) begin
      ph_q.push_back(PH_JUMP); mr_q.push_back(1'($urandom));
    end else begin
      ph_q.push_back(PH_TRAP); mr_q.push_back(1'($urandom));
    end
    lat = 0;
    r0 = retired;
    for (int k = 0; k < ph_q.size(); k++) begin
      @(negedge clk);
      opCode = (ph_q[k] == PH_DECODE) ? op : 6'($urandom);
      mem_ready = mr_q[k];
      #1;
      e = model_out(ph_q[k], op, mem_ready);
      check("outs", 32'(outs), 32'(e));
      check("outs_cntw2", 32'(outs_b), 32'(e));
      check("retired", 32'(retired), 32'(16'(model_cnt)));
      check("retired_cntw2", 32'(retired_b), 32'(2'(model_cnt)));
      if (lat == 0 && (instr_done || illegal)) lat = k + 1;
      if (e[0]) model_cnt++;
      @(posedge clk);
    end
    #1;
    dret = int'(16'(retired - r0));
  endtask

  typedef struct {
    logic [5:0] op;
    int fs;
    int ms;
    int lat;
    int dret;
  } vec_t;

  vec_t tbl[$];
  int lat, dret;
  logic [1:0] wrap_exp[5];
  logic [5:0] pool[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef UDC_JUMP_EN
    jump_en = 1'b1;
`else
    jump_en = 1'b0;
`endif
    tbl.push_back('{R,    0, 0, 4, 1});
    tbl.push_back('{ADDI, 0, 0, 4, 1});
    tbl.push_back('{ORI,  0, 0, 4, 1});
    tbl.push_back('{ANDI, 0, 0, 4, 1});
    tbl.push_back('{SLTI, 0, 0, 4, 1});
    tbl.push_back('{LW,   0, 0, 5, 1});
    tbl.push_back('{LW,   0, 3, 8, 1});
    tbl.push_back('{SW,   0, 0, 4, 1});
    tbl.push_back('{SW,   0, 2, 6, 1});
    tbl.push_back('{BEQ,  0, 0, 3, 1});
    tbl.push_back('{BAD,  0, 0, 3, 0});
    tbl.push_back('{R,    2, 0, 6, 1});
    tbl.push_back('{J,    0, 0, 3, jump_en ? 1 : 0});

    // Reset state is visible before any clock edge.
    rst_n = 1'b0; opCode = 6'd0; mem_ready = 1'b0;
    #1;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rst_cycle();

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fs, tbl[i].ms, lat, dret);
      check($sformatf("latency_op%02h_%0d", tbl[i].op, i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("retire_delta_op%02h_%0d", tbl[i].op, i), 32'(dret), 32'(tbl[i].dret));
    end

    // Reset during a MEM stall of SW: write enable drops asynchronously.
    @(negedge clk); opCode = 6'($urandom); mem_ready = 1'b1; #1;
    check("swrst_fetch_pcw", 32'(PCwrite), 32'd1);
    @(posedge clk);
    @(negedge clk); opCode = SW; mem_ready = 1'b0; @(posedge clk);
    @(negedge clk); opCode = BAD; @(posedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("swrst_mem_enw", 32'(EnW), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("swrst_async_outs", 32'(outs), 32'd0);
    check("swrst_async_retired", 32'(retired), 32'd0);
    model_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    rst_cycle();

    // Small counter wraps: 1, 2, 3, 0, 1.
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      run_instr(ADDI, 0, 0, lat, dret);
      check($sformatf("wrap_%0d", i), 32'(retired_b), 32'(wrap_exp[i]));
    end
    run_instr(BAD, 0, 0, lat, dret);
    check("wrap_after_illegal", 32'(retired_b), 32'd1);

    // Randomized instruction stream with random stalls.
    pool = '{R, ADDI, ORI, ANDI, SLTI, LW, SW, BEQ, J, BAD};
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 9)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), lat, dret);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udc_multicycle.md
Name: udc_multicycle

Overview:
- Multi-cycle main control unit for the MIPS-subset datapath. Successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding in one cycle.
- Stalls on a shared memory ready handshake, flags illegal opcodes and counts retired instructions.
- Sits between the instruction register and the shared instruction/data memory, register bank, ALU-control and PC logic.

Parameters:
OPW, 6, opcode width.
ALUCW, 3, width of AluC (ALU-control op code).
CNTW, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
opCode  in  OPW  opcode field from instruction register; sampled in DECODE.
mem_ready  in  1  memory completed current read/write this cycle.
PCwrite  out  1  load PC.
IRwrite  out  1  load instruction register.
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
BR_en  out  1  register-bank write enable.
AluC  out  ALUCW  ALU operation code.
EnW  out  1  memory write enable.
EnR  out  1  memory read enable.
MUX1  out  1  write-back select: 1 = memory data, 0 = ALUOut.
branch  out  1  conditional PC load on ALU zero.
regDest  out  1  destination register select: 1 = rd, 0 = rt.
ALUsrcA  out  1  ALU A select: 0 = PC, 1 = rs.
ALUsrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
PCsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
illegal  out  1  one-cycle pulse on unknown opcode.
instr_done  out  1  one-cycle pulse in the last state of each retired instruction.
retired  out  CNTW  retired-instruction count.

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP (plus JUMP, see Optional Feature).
- rst_n low: state = RST, op_q = 0, retired = 0, regardless of clk.
- Outputs decode combinationally from state and op_q. In RST every output is 0; RST always moves to FETCH.
- Only signals listed below are asserted in a state; all other outputs are 0.
- FETCH:
  - EnR=1, IorD=0, ALUsrcA=0, ALUsrcB=01, AluC=001, PCsrc=00.
  - PCwrite = IRwrite = mem_ready.
  - Stay while mem_ready=0; go to DECODE when 1.
- DECODE:
  - ALUsrcA=0, ALUsrcB=11, AluC=001.
  - op_q <= opCode.
  - R(000000), ADDI(001000), ORI(001101), ANDI(001100), LW(100011), SW(101011), SLTI(001010) go to EXEC.
  - BEQ(000100) goes to BRANCH. Any other opcode goes to TRAP.
- EXEC:
  - ALUsrcA=1. ALUsrcB = 00 for R, 10 otherwise.
  - AluC: R 000, ADDI/LW/SW 001, ORI 010, ANDI 011, SLTI 100.
  - LW/SW go to MEM; others go to WB.
- MEM:
  - IorD=1. EnR=1 for LW, EnW=1 for SW.
  - Hold until mem_ready=1, then LW goes to WB and SW goes to FETCH with instr_done=1.
- WB:
  - BR_en=1. regDest = 1 for R, else 0. MUX1 = 1 for LW, else 0.
  - instr_done=1, then go to FETCH.
- BRANCH:
  - ALUsrcA=1, ALUsrcB=00, AluC=101, branch=1, PCsrc=01.
  - instr_done=1, then go to FETCH.
- TRAP: illegal=1, no enables, no retire; go to FETCH.
- Latency with mem_ready tied high: BEQ 3 cycles, R/I-type/SW 4, LW 5, illegal 3.
- retired increments by 1 on every instr_done cycle and wraps from 2^CNTW-1 to 0.
- Reset asserted mid-instruction (including inside a MEM stall) aborts immediately; no write enable survives into RST.
- mem_ready is ignored outside FETCH and MEM.
- opCode changing outside DECODE has no effect; op_q governs EXEC/MEM/WB.

Optional Feature:
- Macro UDC_JUMP_EN.
- When defined:
  - opcode 000010 (J) goes from DECODE to JUMP.
  - JUMP asserts PCwrite=1, PCsrc=10, instr_done=1, then goes to FETCH; J takes 3 cycles.
- When undefined:
  - 000010 is illegal and goes to TRAP.
  - PCsrc never equals 10.

Test Plan:
- Reset then opCode=000000, mem_ready=1 -> FETCH, DECODE, EXEC (AluC=000, ALUsrcB=00), WB (BR_en=1, regDest=1); instr_done in cycle 4; retired=1.
- LW 100011 with mem_ready low for 3 cycles in MEM -> EnR=1, IorD=1 held 4 cycles total; WB has MUX1=1, BR_en=1; instruction takes 8 cycles.
- SW 101011 -> EnW=1 only in MEM; BR_en never 1; retired increments at the MEM exit.
- BEQ 000100 -> BRANCH with AluC=101, branch=1, PCsrc=01 at cycle 3; then opcode 111111 -> illegal pulse, retired unchanged.
- rst_n pulled low mid-MEM of SW -> EnW drops to 0 asynchronously and retired=0; after release, RST for 1 cycle with all outputs 0, then FETCH.
- CNTW=2, retire 5 ADDIs -> retired sequence 1, 2, 3, 0, 1. With UDC_JUMP_EN, opcode 000010 -> PCsrc=10, PCwrite=1 at cycle 3.
